// File: rtl/axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_arbiter
// Description : Frame-atomic round-robin arbiter that shares one 64-bit
//               AXI-Stream TX input among N_PORTS requesters. A grant is
//               taken in IDLE and held until the granted port's tlast beat
//               is accepted downstream. Every frame pays one IDLE cycle.
//
// Ports       : clk156         - single clock for all logic
//               reset          - synchronous, active-high reset
//               s_axis_tdata   - requester data, port i at [i*DATA_W +: DATA_W]
//               s_axis_tkeep   - requester byte enables, packed the same way
//               s_axis_tvalid  - per-port valid
//               s_axis_tready  - per-port ready (only the granted bit can be 1)
//               s_axis_tlast   - per-port end of frame
//               m_axis_t*      - muxed stream towards the loopback TX port
//               grant_idx      - granted port, meaningful while busy=1
//               busy           - high while a frame is being forwarded
//               frame_cnt      - completed frames per port, wraps silently
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int CNT_W   = 16
) (
    input  logic                        clk156,
    input  logic                        reset,
    input  logic [N_PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_PORTS*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [N_PORTS-1:0]          s_axis_tvalid,
    output logic [N_PORTS-1:0]          s_axis_tready,
    input  logic [N_PORTS-1:0]          s_axis_tlast,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic [KEEP_W-1:0]           m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [$clog2(N_PORTS)-1:0]  grant_idx,
    output logic                        busy,
    output logic [N_PORTS*CNT_W-1:0]    frame_cnt
);

    localparam int         c_IDX_W = $clog2(N_PORTS);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_XFER  = 1'b1;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_grant_idx;
    logic [c_IDX_W-1:0] r_last_grant;

    logic               w_xfer;
    logic               w_req_found;
    logic [c_IDX_W-1:0] w_next_grant;
    logic [DATA_W-1:0]  w_tdata;
    logic [KEEP_W-1:0]  w_tkeep;
    logic               w_tvalid;
    logic               w_tlast;
    logic               w_accept;
    logic               w_frame_done;

    assign w_xfer = (r_state == c_XFER);

    // Round-robin pick: scan last_grant+1, last_grant+2, ... (mod N_PORTS)
    // and take the first port with tvalid set.
    always_comb begin : b_rr_pick
        int v_idx;
        v_idx        = 0;
        w_req_found  = 1'b0;
        w_next_grant = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            v_idx = (int'(r_last_grant) + k) % N_PORTS;
            if (!w_req_found && s_axis_tvalid[c_IDX_W'(v_idx)]) begin
                w_req_found  = 1'b1;
                w_next_grant = c_IDX_W'(v_idx);
            end
        end
    end

    // Zero-latency mux of the granted port onto the master side.
    always_comb begin : b_out_mux
        w_tdata  = '0;
        w_tkeep  = '0;
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_grant_idx == c_IDX_W'(i)) begin
                w_tdata  = s_axis_tdata[i*DATA_W +: DATA_W];
                w_tkeep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                w_tvalid = s_axis_tvalid[i];
                w_tlast  = s_axis_tlast[i];
            end
        end
    end

    always_comb begin : b_ready
        s_axis_tready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_xfer && (r_grant_idx == c_IDX_W'(i))) begin
                s_axis_tready[i] = m_axis_tready;
            end
        end
    end

    assign m_axis_tdata  = w_tdata;
    assign m_axis_tkeep  = w_tkeep;
    assign m_axis_tvalid = w_xfer & w_tvalid;
    assign m_axis_tlast  = w_xfer & w_tlast;

    assign w_accept     = m_axis_tvalid & m_axis_tready;
    assign w_frame_done = w_accept & m_axis_tlast;

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_grant_idx  <= '0;
            // Last grant on the highest index makes port 0 win first.
            r_last_grant <= c_IDX_W'(N_PORTS - 1);
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req_found) begin
                        r_grant_idx <= w_next_grant;
                        r_state     <= c_XFER;
                    end
                end
                c_XFER: begin
                    if (w_frame_done) begin
                        r_last_grant <= r_grant_idx;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < N_PORTS; g++) begin : g_frame_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk156) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_frame_done && (r_grant_idx == c_IDX_W'(g))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign frame_cnt[g*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    assign grant_idx = r_grant_idx;
    assign busy      = w_xfer;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_arbiter
// Description : Self-checking bench for axis_frame_arbiter. Frames are queued
//               per port; a round-robin reference over whole frames predicts
//               the beat order on the master side, the grant of each beat
//               and the per-port frame counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_arbiter;

    localparam int N      = 4;
    localparam int DW     = 64;
    localparam int KW     = DW / 8;
    localparam int CW     = 8;     // small counters keep the wrap scenario short
    localparam int IW     = 2;
    localparam int BUDGET = 20000;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        int            gap;   // cycles tvalid stays low before this beat
        int            port;
    } beat_t;

    logic              clk156 = 1'b0;
    logic              reset;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N-1:0]      s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [IW-1:0]     grant_idx;
    logic              busy;
    logic [N*CW-1:0]   frame_cnt;

    always #5 clk156 = ~clk156;

    axis_frame_arbiter #(
        .N_PORTS (N),
        .DATA_W  (DW),
        .KEEP_W  (KW),
        .CNT_W   (CW)
    ) dut (
        .clk156        (clk156),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    beat_t         pq[N][$];
    beat_t         exp_q[$];
    int            wcnt[N];
    int            model_last;
    logic [CW-1:0] cnt_model[N];
    bit            exp_busy;
    int            n_vec;
    int            n_err;

    function automatic void model_init();
        model_last = N - 1;
        exp_busy   = 1'b0;
        exp_q.delete();
        for (int p = 0; p < N; p++) begin
            cnt_model[p] = '0;
            wcnt[p]      = 0;
            pq[p].delete();
        end
    endfunction

    task automatic push_beat(input int p, input logic [DW-1:0] d, input logic l, input int gap);
        beat_t b;
        b.d    = d;
        b.k    = KW'($urandom_range(1, (1 << KW) - 1));
        b.l    = l;
        b.gap  = gap;
        b.port = p;
        pq[p].push_back(b);
    endtask

    task automatic add_frame(input int p, input int len, input int gmax);
        for (int i = 0; i < len; i++) begin
            push_beat(p, {$urandom, $urandom}, (i == len - 1),
                      (i == 0) ? 0 : int'($urandom_range(0, gmax)));
        end
    endtask

    // Whole-frame round robin over the queued traffic: the next frame comes
    // from the first non-empty port after the previous winner.
    function automatic void build_expected();
        beat_t tmp[N][$];
        bit    found;
        for (int p = 0; p < N; p++) tmp[p] = pq[p];
        do begin
            found = 1'b0;
            for (int k = 1; k <= N && !found; k++) begin
                int p;
                p = (model_last + k) % N;
                if (tmp[p].size() > 0) begin
                    found = 1'b1;
                    while (tmp[p].size() > 0) begin
                        beat_t b;
                        b = tmp[p].pop_front();
                        exp_q.push_back(b);
                        if (b.l) break;
                    end
                    model_last   = p;
                    cnt_model[p] = cnt_model[p] + 1'b1;
                end
            end
        end while (found);
    endfunction

    // Drives queued frames cycle by cycle and checks every cycle at negedge.
    // rdy_mode 0: random ready with rdy_pct percent; 1: ready toggles 1,0,1,0.
    task automatic run_traffic(input int rdy_mode, input int rdy_pct);
        int            cyc;
        bit            nb;
        int            gp;
        logic          mv;
        logic [N-1:0]  tr_exp;
        beat_t         b;
        build_expected();
        cyc = 0;
        while (exp_q.size() > 0 || exp_busy) begin
            if (cyc >= BUDGET) begin
                n_vec++; n_err++;
                $display("FAIL timeout: ran %0d cycles, limit %0d", cyc, BUDGET);
                break;
            end
            for (int p = 0; p < N; p++) begin
                if (pq[p].size() > 0 && wcnt[p] == 0) begin
                    s_axis_tvalid[p]          = 1'b1;
                    s_axis_tdata[p*DW +: DW]  = pq[p][0].d;
                    s_axis_tkeep[p*KW +: KW]  = pq[p][0].k;
                    s_axis_tlast[p]           = pq[p][0].l;
                end else begin
                    s_axis_tvalid[p]          = 1'b0;
                    s_axis_tdata[p*DW +: DW]  = {$urandom, $urandom};
                    s_axis_tkeep[p*KW +: KW]  = KW'($urandom);
                    s_axis_tlast[p]           = 1'($urandom_range(0, 1));
                    if (wcnt[p] > 0) wcnt[p]--;
                end
            end
            if (rdy_mode == 1) m_axis_tready = ((cyc % 2) == 0);
            else               m_axis_tready = ($urandom_range(0, 99) < rdy_pct);

            @(negedge clk156);
            nb = exp_busy;
            gp = (exp_q.size() > 0) ? exp_q[0].port : 0;
            n_vec++;
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL busy: got %0b expected %0b (cycle %0d)", busy, exp_busy, cyc);
            end
            if (exp_busy) begin
                mv         = s_axis_tvalid[gp];
                tr_exp     = '0;
                tr_exp[gp] = m_axis_tready;
                n_vec++;
                if (grant_idx !== IW'(gp)) begin
                    n_err++;
                    $display("FAIL grant_idx: got %0d expected %0d", grant_idx, gp);
                end
                n_vec++;
                if (m_axis_tvalid !== mv) begin
                    n_err++;
                    $display("FAIL m_tvalid: got %0b expected %0b", m_axis_tvalid, mv);
                end
                n_vec++;
                if (s_axis_tready !== tr_exp) begin
                    n_err++;
                    $display("FAIL s_tready: got %b expected %b", s_axis_tready, tr_exp);
                end
                if (mv && m_axis_tready) begin
                    b = exp_q.pop_front();
                    n_vec++;
                    if (m_axis_tdata !== b.d) begin
                        n_err++;
                        $display("FAIL m_tdata: got %h expected %h (port %0d)", m_axis_tdata, b.d, gp);
                    end
                    n_vec++;
                    if (m_axis_tkeep !== b.k) begin
                        n_err++;
                        $display("FAIL m_tkeep: got %h expected %h", m_axis_tkeep, b.k);
                    end
                    n_vec++;
                    if (m_axis_tlast !== b.l) begin
                        n_err++;
                        $display("FAIL m_tlast: got %0b expected %0b", m_axis_tlast, b.l);
                    end
                    void'(pq[gp].pop_front());
                    if (pq[gp].size() > 0) wcnt[gp] = pq[gp][0].gap;
                    if (b.l) nb = 1'b0;
                end
            end else begin
                n_vec++;
                if (m_axis_tvalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_m_tvalid: got %0b expected 0", m_axis_tvalid);
                end
                n_vec++;
                if (s_axis_tready !== '0) begin
                    n_err++;
                    $display("FAIL idle_s_tready: got %b expected 0000", s_axis_tready);
                end
                if (|s_axis_tvalid) nb = 1'b1;
            end
            exp_busy = nb;
            @(posedge clk156); #1;
            cyc++;
        end
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        for (int p = 0; p < N; p++) begin
            n_vec++;
            if (frame_cnt[p*CW +: CW] !== cnt_model[p]) begin
                n_err++;
                $display("FAIL frame_cnt[%0d]: got %0d expected %0d", p, frame_cnt[p*CW +: CW], cnt_model[p]);
            end
        end
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        reset = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        s_axis_tvalid = 4'b0100;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_vec++;
        if (grant_idx !== '0) begin n_err++; $display("FAIL rst_grant: got %0d expected 0", grant_idx); end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_tvalid: got %0b expected 0", m_axis_tvalid); end
        n_vec++;
        if (s_axis_tready !== '0) begin n_err++; $display("FAIL rst_s_tready: got %b expected 0000", s_axis_tready); end
        n_vec++;
        if (frame_cnt !== '0) begin n_err++; $display("FAIL rst_frame_cnt: got %h expected 0", frame_cnt); end
        @(posedge clk156); #1;
        reset         = 1'b0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        model_init();
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 3; i++) push_beat(2, DW'(8'hA0 + i), (i == 2), 0);
        run_traffic(0, 100);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++) add_frame(p, 2, 0);
        run_traffic(0, 100);
    endtask

    task automatic test_stall();
        push_beat(1, 64'hB0, 1'b0, 0);
        push_beat(1, 64'hB1, 1'b1, 5);
        push_beat(3, 64'hD3, 1'b1, 0);
        run_traffic(0, 100);
    endtask

    task automatic test_backpressure();
        add_frame(0, 4, 0);
        run_traffic(1, 0);
    endtask

    task automatic test_reset_midframe();
        s_axis_tvalid             = '0;
        s_axis_tvalid[3]          = 1'b1;
        s_axis_tdata[3*DW +: DW]  = 64'hD0;
        s_axis_tkeep[3*KW +: KW]  = '1;
        s_axis_tlast[3]           = 1'b0;
        m_axis_tready             = 1'b1;
        @(posedge clk156); #1;
        @(negedge clk156);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %0b expected 1", busy); end
        @(posedge clk156); #1;
        s_axis_tdata[3*DW +: DW] = 64'hD1;
        reset                    = 1'b1;
        @(posedge clk156); #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_m_tvalid: got %0b expected 0", m_axis_tvalid); end
        n_vec++;
        if (s_axis_tready !== '0) begin n_err++; $display("FAIL mid_s_tready: got %b expected 0000", s_axis_tready); end
        n_vec++;
        if (grant_idx !== '0) begin n_err++; $display("FAIL mid_grant: got %0d expected 0", grant_idx); end
        n_vec++;
        if (frame_cnt !== '0) begin n_err++; $display("FAIL mid_frame_cnt: got %h expected 0", frame_cnt); end
        reset         = 1'b0;
        s_axis_tvalid = '0;
        model_init();
        add_frame(3, 4, 0);
        add_frame(0, 1, 0);
        run_traffic(0, 100);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < (1 << CW); i++) push_beat(1, DW'(i), 1'b1, 0);
        run_traffic(0, 100);
    endtask

    task automatic test_random();
        int pct[4] = '{100, 60, 30, 80};
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < N; p++) begin
                int nf;
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 6), 3);
            end
            run_traffic(0, pct[r]);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        model_init();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_reset_midframe();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
